// File: rtl/demux16_collector.sv
// Serial 1:16 demux collector: routes in to slot select/index, tracks filled slots, pulses frame_done.
// One-clock write latency, no backpressure; optional parity output via DEMUX16_PARITY_EN.
module demux16_collector #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic [3:0]       select,
  input  logic             auto_mode,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] written,
  output logic [3:0]       index,
  output logic             frame_done
`ifdef DEMUX16_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] written_q, written_d;
  logic [3:0]       index_q, index_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       target;
  logic [WIDTH-1:0] written_set;

  always_comb begin
    out_d        = out_q;
    written_d    = written_q;
    index_d      = index_q;
    frame_done_d = 1'b0;
    target       = auto_mode ? index_q : select;
    written_set  = written_q | ({{(WIDTH-1){1'b0}}, 1'b1} << target);
    if (clear) begin
      written_d = '0;
      index_d   = '0;
    end else if (in_valid) begin
      out_d[target] = in;
      if (auto_mode) index_d = index_q + 4'd1;
      // A completing write restarts the mask directly, so all-ones is never visible.
      if (&written_set) begin
        written_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        written_d = written_set;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      written_q    <= '0;
      index_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      written_q    <= written_d;
      index_q      <= index_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out        = out_q;
  assign written    = written_q;
  assign index      = index_q;
  assign frame_done = frame_done_q;

`ifdef DEMUX16_PARITY_EN
  logic parity_q, parity_d;

  // Parity of the completed word, including the bit written in the completing cycle.
  always_comb begin
    parity_d = parity_q;
    if (frame_done_d) parity_d = ^out_d;
  end

  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_demux16_collector.sv
// Bench for demux16_collector: vector table, directed multi-cycle sequences, randomized model compare.
module tb_demux16_collector;

  logic        clk = 1'b0;
  logic        reset, din, in_valid, auto_mode, clear;
  logic [3:0]  select;
  logic [15:0] out, written;
  logic [3:0]  index;
  logic        frame_done;
`ifdef DEMUX16_PARITY_EN
  logic        parity;
`endif

  demux16_collector dut (
    .clk        (clk),
    .reset      (reset),
    .in         (din),
    .in_valid   (in_valid),
    .select     (select),
    .auto_mode  (auto_mode),
    .clear      (clear),
    .out        (out),
    .written    (written),
    .index      (index),
    .frame_done (frame_done)
`ifdef DEMUX16_PARITY_EN
    ,
    .parity     (parity)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: slot contents and fill flags as plain bit arrays, pointer as an integer.
  bit m_out[16];
  bit m_wr[16];
  int m_idx;
  bit m_done;
  bit m_par;

  function automatic logic [15:0] pack(input bit a[16]);
    logic [15:0] v;
    for (int k = 0; k < 16; k++) v[k] = a[k];
    return v;
  endfunction

  function automatic void model(input bit r, input bit c, input bit v, input bit d,
                                input int sel, input bit au);
    int t;
    int filled;
    if (r) begin
      for (int k = 0; k < 16; k++) begin m_out[k] = 0; m_wr[k] = 0; end
      m_idx = 0; m_done = 0; m_par = 0;
    end else if (c) begin
      for (int k = 0; k < 16; k++) m_wr[k] = 0;
      m_idx = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (v) begin
        t = au ? m_idx : sel;
        m_out[t] = d;
        m_wr[t]  = 1;
        if (au) m_idx = (m_idx + 1) % 16;
        filled = 0;
        for (int k = 0; k < 16; k++) filled += m_wr[k];
        if (filled == 16) begin
          for (int k = 0; k < 16; k++) m_wr[k] = 0;
          m_done = 1;
          m_par  = 0;
          for (int k = 0; k < 16; k++) m_par ^= m_out[k];
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit v, input bit d,
                     input logic [3:0] sel, input bit au);
    reset = r; clear = c; in_valid = v; din = d; select = sel; auto_mode = au;
    @(posedge clk);
    #1;
    model(r, c, v, d, int'(sel), au);
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".out"}, {16'h0, out}, {16'h0, pack(m_out)});
    chk({nm, ".written"}, {16'h0, written}, {16'h0, pack(m_wr)});
    chk({nm, ".index"}, {28'h0, index}, m_idx);
    chk({nm, ".frame_done"}, {31'h0, frame_done}, {31'h0, m_done});
`ifdef DEMUX16_PARITY_EN
    chk({nm, ".parity"}, {31'h0, parity}, {31'h0, m_par});
`endif
  endtask

  typedef struct {
    bit          rst, clr, vld, d;
    logic [3:0]  sel;
    bit          au;
    logic [15:0] e_out, e_wr;
    logic [3:0]  e_idx;
    bit          e_done;
  } vec_t;

  vec_t vecs[9];
  logic [15:0] word;
  int done_cnt;

  initial begin
    vecs[0] = '{1, 0, 1, 1, 4'd0, 1, 16'h0000, 16'h0000, 4'd0, 0};
    vecs[1] = '{1, 0, 1, 1, 4'd0, 1, 16'h0000, 16'h0000, 4'd0, 0};
    vecs[2] = '{0, 0, 1, 1, 4'd9, 0, 16'h0200, 16'h0200, 4'd0, 0};
    vecs[3] = '{0, 0, 1, 0, 4'd9, 0, 16'h0000, 16'h0200, 4'd0, 0};
    vecs[4] = '{0, 0, 1, 1, 4'd3, 1, 16'h0001, 16'h0201, 4'd1, 0};
    vecs[5] = '{0, 0, 1, 1, 4'd3, 1, 16'h0003, 16'h0203, 4'd2, 0};
    vecs[6] = '{0, 0, 0, 1, 4'd7, 1, 16'h0003, 16'h0203, 4'd2, 0};
    vecs[7] = '{0, 1, 1, 1, 4'd7, 1, 16'h0003, 16'h0000, 4'd0, 0};
    vecs[8] = '{0, 0, 1, 0, 4'd7, 1, 16'h0002, 16'h0001, 4'd1, 0};

    reset = 1; clear = 0; in_valid = 0; din = 0; select = 0; auto_mode = 0;
    cyc(1, 0, 0, 0, 4'd0, 0);
    chk("reset_state.out", {16'h0, out}, 32'h0);
    chk("reset_state.frame_done", {31'h0, frame_done}, 32'h0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].clr, vecs[i].vld, vecs[i].d, vecs[i].sel, vecs[i].au);
      chk($sformatf("vec%0d.out", i), {16'h0, out}, {16'h0, vecs[i].e_out});
      chk($sformatf("vec%0d.written", i), {16'h0, written}, {16'h0, vecs[i].e_wr});
      chk($sformatf("vec%0d.index", i), {28'h0, index}, {28'h0, vecs[i].e_idx});
      chk($sformatf("vec%0d.frame_done", i), {31'h0, frame_done}, {31'h0, vecs[i].e_done});
    end

    // Auto fill of A5C3, LSB first.
    cyc(1, 0, 0, 0, 4'd0, 0);
    word = 16'hA5C3;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, word[i], 4'd0, 1);
      done_cnt += frame_done;
      chk($sformatf("fill.done_at%0d", i), {31'h0, frame_done}, (i == 15) ? 32'h1 : 32'h0);
    end
    chk("fill.out", {16'h0, out}, 32'hA5C3);
    chk("fill.written", {16'h0, written}, 32'h0);
    chk("fill.index", {28'h0, index}, 32'h0);
`ifdef DEMUX16_PARITY_EN
    chk("fill.parity", {31'h0, parity}, 32'h0);
`endif
    cyc(0, 0, 0, 0, 4'd0, 1);
    done_cnt += frame_done;
    chk("fill.done_count", done_cnt, 32'd1);
    chk("fill.out_hold", {16'h0, out}, 32'hA5C3);

    // Clear mid-frame drops the coincident write.
    cyc(1, 0, 0, 0, 4'd0, 0);
    word = 16'h0016;
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, word[i], 4'd0, 1);
    cyc(0, 1, 1, 1, 4'd0, 1);
    chk("clear.written", {16'h0, written}, 32'h0);
    chk("clear.index", {28'h0, index}, 32'h0);
    chk("clear.out", {16'h0, out}, 32'h0016);
    chk_model("clear");

    // Auto slots 0-7, then direct 15 down to 8.
    cyc(1, 0, 0, 0, 4'd0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 4'd0, 1);
    for (int s = 15; s >= 8; s--) begin
      cyc(0, 0, 1, 1, 4'(s), 0);
      chk($sformatf("mix.done_s%0d", s), {31'h0, frame_done}, (s == 8) ? 32'h1 : 32'h0);
    end
    chk("mix.index", {28'h0, index}, 32'd8);
    chk("mix.out", {16'h0, out}, 32'hFFFF);
    chk("mix.written", {16'h0, written}, 32'h0);

    // Reset mid-frame, full frame afterwards, then back-to-back write.
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 4'd0, 1);
    cyc(1, 0, 0, 0, 4'd0, 1);
    chk("rstmid.out", {16'h0, out}, 32'h0);
    chk("rstmid.written", {16'h0, written}, 32'h0);
    chk("rstmid.index", {28'h0, index}, 32'h0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 1, 4'd0, 1);
    chk("rstmid.frame_done", {31'h0, frame_done}, 32'h1);
    chk("rstmid.out_full", {16'h0, out}, 32'hFFFF);
    cyc(0, 0, 1, 0, 4'd0, 1);
    chk("b2b.written", {16'h0, written}, 32'h0001);
    chk("b2b.frame_done", {31'h0, frame_done}, 32'h0);
    chk_model("b2b");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 8), 1'($urandom), 4'($urandom),
          ($urandom_range(0, 3) != 0));
      chk_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
